lsu_mem_ctrl: RTL and testbench
===============================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 10, giving the byte-address width of the attached memory (2**ADDR_BITS bytes).
REQ-002 SHALL have ports (clock and reset first):
  clk  in  1  rising-edge clock
  rst  in  1  asynchronous active-low reset
  req_valid  in  1  core request present
  req_ready  out  1  controller accepts request
  req_we  in  1  1=store, 0=load
  req_funct3  in  3  RV32I width/sign code
  req_addr  in  32  byte address
  req_wdata  in  32  store data, right-justified
  rsp_valid  out  1  response present
  rsp_ready  in  1  core accepts response
  rsp_rdata  out  32  load result, extended
  rsp_err  out  1  misaligned/illegal/out-of-range
  mem_w_enb  out  1  memory write enable
  mem_r_enb  out  1  memory read enable
  mem_addr  out  32  word-aligned address to memory
  mem_w_data  out  32  full word to memory
  mem_r_data  in  32  memory read data, combinational on mem_addr
REQ-003 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 SHALL implement FSM states IDLE, RD, WR, RSP; req_ready=1 only in IDLE.
REQ-005 SHALL capture req_we, req_funct3, req_addr, req_wdata on clk edge with req_valid&&req_ready.
REQ-006 Transitions: load IDLE->RD->RSP; SW IDLE->WR->RSP; SB/SH IDLE->RD->WR->RSP (read-modify-write); error IDLE->RSP without memory access.
REQ-007 mem_r_enb=1 only in RD, mem_w_enb=1 only in WR; both never high together; mem_addr = {captured addr[31:2],2'b00} in RD/WR, 0 otherwise.
REQ-008 In RD, SHALL register mem_r_data into a word buffer at clock edge.
REQ-009 Loads: LB(000) sign-extend, LBU(100) zero-extend byte at lane addr[1:0]; LH(001)/LHU(101) halfword at lane addr[1]; LW(010) full word.
REQ-010 Stores: SB(000) replace byte lane addr[1:0], SH(001) halfword lane addr[1], using low bits of req_wdata; other lanes from buffered read word; SW(010) writes req_wdata directly.
REQ-011 rsp_err=1: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 011/110/111; store funct3 >=011.
REQ-012 In RSP, rsp_valid=1 held stable with rsp_rdata/rsp_err until rsp_ready; next edge returns to IDLE.
REQ-013 rsp_rdata=0 for stores and for any error response.
REQ-014 Latency accept->rsp_valid: load 2 cycles, SW 2, SB/SH 3, error 1.
REQ-015 rsp_ready without rsp_valid SHALL be ignored; req_valid outside IDLE SHALL not be captured.

Reset
REQ-016 rst low SHALL immediately force IDLE, req_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_w_enb=0, mem_r_enb=0, mem_addr=0, mem_w_data=0, buffers 0.
REQ-017 Reset during RD/WR SHALL abort the access with no memory write after assertion.

Configuration
REQ-018 Macro LSU_BOUND_CHECK_EN: when defined, any access with req_addr[31:ADDR_BITS]!=0 SHALL take the error path (rsp_err=1, no memory access); when undefined, upper address bits pass to mem_addr unchecked.

Structure
REQ-019 Package lsu_pkg SHALL hold funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and state encoding.
REQ-020 Combinational sub-module lsu_lane_align SHALL perform load extraction/extension and store merge.

Verification
REQ-021 Memory word 0x8000_00F0 at 0x10; LB addr 0x10 -> rsp_rdata 0xFFFF_FFF0, rsp_err 0, 2 cycles.
REQ-022 Same word; LHU addr 0x12 -> rsp_rdata 0x0000_8000; LH addr 0x12 -> 0xFFFF_8000.
REQ-023 Word 0x1122_3344 at 0x20; SB addr 0x21 wdata 0xAB -> one RD, one WR, word becomes 0x1122_AB44, latency 3.
REQ-024 LW addr 0x22 -> rsp_err 1, rsp_rdata 0, mem_r_enb/mem_w_enb never high.
REQ-025 rsp_ready held low 5 cycles after load -> rsp_valid and data stable, req_ready 0 throughout.
REQ-026 rst asserted in WR of SH -> enables drop same cycle, memory unchanged; with LSU_BOUND_CHECK_EN, SW addr 0x400 (ADDR_BITS=10) -> rsp_err 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory controller: funct3 codes,
// FSM state encoding, captured-request payload and access legality check.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RSP  = 2'd3;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Misaligned access or funct3 code with no meaning for this direction.
    function automatic logic access_err(input logic we, input logic [2:0] f3,
                                        input logic [1:0] lo);
        logic err;
        case (f3)
            F3_B:         err = 1'b0;
            F3_H:         err = lo[0];
            F3_W:         err = (lo != 2'b00);
            F3_BU, F3_HU: err = we;
            default:      err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: load extraction with sign/zero extension and
// sub-word store merge into a previously read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ld_data_c,
    output logic [XLEN-1:0] st_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word >> {lane, 3'b000});
        half_sel = 16'(word >> {lane[1], 4'b0000});
        case (funct3)
            F3_B:    ld_data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data_c = {24'd0, byte_sel};
            F3_H:    ld_data_c = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data_c = {16'd0, half_sel};
            default: ld_data_c = word;
        endcase
    end

    // Untouched lanes keep the buffered read word; full-word stores bypass it.
    always_comb begin
        st_data_c = wdata;
        case (funct3)
            F3_B: begin
                st_data_c = word;
                st_data_c[{lane, 3'b000} +: 8] = wdata[7:0];
            end
            F3_H: begin
                st_data_c = word;
                st_data_c[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: st_data_c = wdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller with read-modify-write for SB/SH.
// Define LSU_BOUND_CHECK_EN to reject accesses beyond 2**ADDR_BITS bytes.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            mem_w_enb,
    output logic            mem_r_enb,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_w_data,
    input  logic [XLEN-1:0] mem_r_data
);

`ifdef LSU_BOUND_CHECK_EN
    localparam bit BOUND_EN = 1'b1;
`else
    localparam bit BOUND_EN = 1'b0;
`endif

    logic [1:0]      state_q, state_d;
    lsu_req_t        req_q;
    logic            err_q;
    logic [XLEN-1:0] rbuf_q;
    logic            acc_err_c;
    logic            oob_c;
    logic [XLEN-1:0] ld_data_c;
    logic [XLEN-1:0] st_data_c;
    logic            accept_c;

    assign oob_c     = BOUND_EN && ((req_addr >> ADDR_BITS) != '0);
    assign acc_err_c = access_err(req_we, req_funct3, req_addr[1:0]) || oob_c;
    assign accept_c  = (state_q == ST_IDLE) && req_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (acc_err_c)                state_d = ST_RSP;
                    else if (!req_we)             state_d = ST_RD;
                    else if (req_funct3 == F3_W)  state_d = ST_WR;
                    else                          state_d = ST_RD;
                end
            end
            ST_RD:   state_d = req_q.we ? ST_WR : ST_RSP;
            ST_WR:   state_d = ST_RSP;
            ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture and read-word buffer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q  <= '0;
            err_q  <= 1'b0;
            rbuf_q <= '0;
        end else begin
            if (accept_c) begin
                req_q <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                err_q <= acc_err_c;
            end
            if (state_q == ST_RD) rbuf_q <= mem_r_data;
        end
    end

    lsu_lane_align u_align (
        .word      (rbuf_q),
        .funct3    (req_q.funct3),
        .lane      (req_q.addr[1:0]),
        .wdata     (req_q.wdata),
        .ld_data_c (ld_data_c),
        .st_data_c (st_data_c)
    );

    // Outputs decode straight from state so reset drops the enables at once.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        rsp_valid  = (state_q == ST_RSP);
        rsp_err    = (state_q == ST_RSP) && err_q;
        mem_r_enb  = (state_q == ST_RD);
        mem_w_enb  = (state_q == ST_WR);
        mem_addr   = '0;
        mem_w_data = '0;
        rsp_rdata  = '0;
        if ((state_q == ST_RD) || (state_q == ST_WR))
            mem_addr = {req_q.addr[XLEN-1:2], 2'b00};
        if (state_q == ST_WR)
            mem_w_data = st_data_c;
        if ((state_q == ST_RSP) && !req_q.we && !err_q)
            rsp_rdata = ld_data_c;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed requests queue expected
// responses, a negedge monitor pops and checks them against the DUT.
module tb_lsu_mem_ctrl;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_w_enb;
    logic        mem_r_enb;
    logic [31:0] mem_addr;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    logic [31:0] mem [0:255];
    exp_t        exp_q[$];
    exp_t        cur;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          nrd = 0;
    int          nwr = 0;
    int          nboth = 0;
    int          rsp_cnt = 0;
    bit          in_rsp = 1'b0;
    logic [31:0] seen_addr = 32'd0;

    lsu_mem_ctrl #(.ADDR_BITS(10)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_w_enb(mem_w_enb), .mem_r_enb(mem_r_enb),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mem_r_data = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_w_enb) mem[mem_addr[9:2]] <= mem_w_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                                input int r, input int w, input logic [31:0] addr);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat; e.nrd = r; e.nwr = w; e.addr = addr;
        return e;
    endfunction

    // Response monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            in_rsp = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc; nrd = 0; nwr = 0; nboth = 0;
            end
            if (mem_r_enb) begin nrd++; seen_addr = mem_addr; end
            if (mem_w_enb) begin nwr++; seen_addr = mem_addr; end
            if (mem_r_enb && mem_w_enb) nboth++;
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_unexpected actual=%h required=none", rsp_rdata);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("rsp_rdata", rsp_rdata, cur.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                        chk("latency", 32'(cyc - acc_cyc), 32'(cur.lat));
                        chk("rd_cycles", 32'(nrd), 32'(cur.nrd));
                        chk("wr_cycles", 32'(nwr), 32'(cur.nwr));
                        chk("rd_wr_overlap", 32'(nboth), 32'd0);
                        if (cur.nrd + cur.nwr > 0) chk("mem_addr", seen_addr, cur.addr);
                    end
                    in_rsp = 1'b1;
                end else begin
                    chk("hold_rdata", rsp_rdata, cur.rdata);
                    chk("hold_err", 32'(rsp_err), 32'(cur.err));
                    chk("hold_req_ready", 32'(req_ready), 32'd0);
                end
                if (rsp_ready) begin
                    in_rsp = 1'b0;
                    rsp_cnt++;
                end
            end
        end
    end

    task automatic wait_rsp(input int target);
        int t = 0;
        while (rsp_cnt < target && t < 100) begin
            @(posedge clk); #1; t++;
        end
        if (rsp_cnt < target) begin
            checks++; failures++;
            $display("FAIL rsp_timeout actual=%0d required=%0d", rsp_cnt, target);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input exp_t e, input bit linger);
        int target = rsp_cnt + 1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        if (linger) begin
            req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h55;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (rsp_ready) wait_rsp(target);
    endtask

    initial begin
        int tgt;
        int t;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[32'h10 >> 2] = 32'h8000_00F0;
        mem[32'h20 >> 2] = 32'h1122_3344;
        mem[32'h30 >> 2] = 32'hDEAD_BEEF;

        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_enables", {30'd0, mem_w_enb, mem_r_enb}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_w_data", mem_w_data, 32'd0);
        @(posedge clk); #1; rst = 1'b1;

        issue(1'b0, 3'b000, 32'h10, 32'd0, mk(32'hFFFF_FFF0, 1'b0, 2, 1, 0, 32'h10), 1'b0);
        issue(1'b0, 3'b101, 32'h12, 32'd0, mk(32'h0000_8000, 1'b0, 2, 1, 0, 32'h10), 1'b0);
        issue(1'b0, 3'b001, 32'h12, 32'd0, mk(32'hFFFF_8000, 1'b0, 2, 1, 0, 32'h10), 1'b0);
        issue(1'b0, 3'b100, 32'h13, 32'd0, mk(32'h0000_0080, 1'b0, 2, 1, 0, 32'h10), 1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'd0, mk(32'h8000_00F0, 1'b0, 2, 1, 0, 32'h10), 1'b0);

        issue(1'b1, 3'b000, 32'h21, 32'hFFFF_FFAB, mk(32'd0, 1'b0, 3, 1, 1, 32'h20), 1'b0);
        chk("mem_sb", mem[8], 32'h1122_AB44);
        issue(1'b0, 3'b010, 32'h22, 32'd0, mk(32'd0, 1'b1, 1, 0, 0, 32'd0), 1'b0);

        issue(1'b1, 3'b001, 32'h32, 32'hAAAA_1234, mk(32'd0, 1'b0, 3, 1, 1, 32'h30), 1'b0);
        chk("mem_sh", mem[12], 32'h1234_BEEF);
        issue(1'b0, 3'b000, 32'h33, 32'd0, mk(32'h0000_0012, 1'b0, 2, 1, 0, 32'h30), 1'b0);
        issue(1'b0, 3'b000, 32'h31, 32'd0, mk(32'hFFFF_FFBE, 1'b0, 2, 1, 0, 32'h30), 1'b0);
        issue(1'b1, 3'b010, 32'h34, 32'hCAFE_F00D, mk(32'd0, 1'b0, 2, 0, 1, 32'h34), 1'b0);
        chk("mem_sw", mem[13], 32'hCAFE_F00D);

        issue(1'b0, 3'b001, 32'h11, 32'd0, mk(32'd0, 1'b1, 1, 0, 0, 32'd0), 1'b0);
        issue(1'b1, 3'b001, 32'h23, 32'h1, mk(32'd0, 1'b1, 1, 0, 0, 32'd0), 1'b0);
        issue(1'b0, 3'b011, 32'h20, 32'd0, mk(32'd0, 1'b1, 1, 0, 0, 32'd0), 1'b0);
        issue(1'b1, 3'b011, 32'h20, 32'h9, mk(32'd0, 1'b1, 1, 0, 0, 32'd0), 1'b0);
        issue(1'b1, 3'b100, 32'h20, 32'h9, mk(32'd0, 1'b1, 1, 0, 0, 32'd0), 1'b0);
        chk("mem_err_untouched", mem[8], 32'h1122_AB44);

        // Request held high while busy must not be taken as a second access.
        issue(1'b0, 3'b010, 32'h20, 32'd0, mk(32'h1122_AB44, 1'b0, 2, 1, 0, 32'h20), 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_req_ignored", mem[16], 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        rsp_ready = 1'b0;
        tgt = rsp_cnt + 1;
        issue(1'b0, 3'b010, 32'h30, 32'd0, mk(32'h1234_BEEF, 1'b0, 2, 1, 0, 32'h30), 1'b0);
        t = 0;
        while (!rsp_valid && t < 20) begin @(posedge clk); #1; t++; end
        repeat (5) @(posedge clk);
        #1; rsp_ready = 1'b1;
        wait_rsp(tgt);

`ifdef LSU_BOUND_CHECK_EN
        issue(1'b1, 3'b010, 32'h400, 32'h0BAD_F00D, mk(32'd0, 1'b1, 1, 0, 0, 32'd0), 1'b0);
        chk("mem_oob_untouched", mem[0], 32'd0);
`else
        issue(1'b1, 3'b010, 32'h400, 32'h0BAD_F00D, mk(32'd0, 1'b0, 2, 0, 1, 32'h400), 1'b0);
        chk("mem_wrap_write", mem[0], 32'h0BAD_F00D);
`endif

        // Reset landing in the write phase of a halfword read-modify-write.
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h22; req_wdata = 32'h0000_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("sh_in_wr", 32'(mem_w_enb), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_w_enb", 32'(mem_w_enb), 32'd0);
        chk("abort_r_enb", 32'(mem_r_enb), 32'd0);
        chk("abort_mem_addr", mem_addr, 32'd0);
        chk("abort_mem_w_data", mem_w_data, 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_unchanged", mem[8], 32'h1122_AB44);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("leftover_expect", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
